irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Memory-mapped interrupt controller between the interrupt sources (tc0.IRQ, tc1.IRQ, external interrupt) and the CPU's `irq` input. It latches edge- or level-type requests, applies a per-source mask, and resolves priority with a fixed scheme: lowest index wins. It tracks nesting through a claim/complete handshake, so the CPU sees only requests of strictly higher priority than the one in service. Software reaches it as one more SystemBridge device, using the same WE/Addr/Din/Dout style as TC.

## Interface
- `N_SRC`, default 6: number of interrupt sources, 1..16; source 0 has the highest priority.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `we`  in  1  register write strobe from SystemBridge.
- `re`  in  1  register read strobe; ignored when `we`=1.
- `addr`  in  3  word offset (bus address bits [4:2]).
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational from `addr` and current state.
- `irq_in`  in  N_SRC  raw source requests, active-high, synchronous to `clk`.
- `irq_out`  out  N_SRC  eligible request vector to the CPU `irq` port.
- `irq_req`  out  1  OR of `irq_out`.

## Operation
- **Registers** (reads of unused offsets return 0; writes to them are ignored):
  - 0 PENDING: read pending[N-1:0]; write-1-to-clear, edge-mode bits only.
  - 1 MASK: read/write, 1 = enabled.
  - 2 EDGE: read/write, 1 = rising-edge latched, 0 = level.
  - 3 CLAIM/EOI:
    - Read returns {valid at bit31, id at [3:0]}.
    - Read with `re`=1 performs a claim.
    - Write performs a complete for id `din[3:0]`.
  - 4 RAW: read-only, the registered samples `samp`.
  - 5 INSERVICE: read-only, in-service bit vector.
- **Sampling**: `samp <= irq_in` every cycle.
- **Edge bits**: pending set when `irq_in & ~samp`; cleared by a W1C write or by a claim of that id.
- **Level bits**: `pending <= irq_in` every cycle; W1C and claim do not clear them. Software clears the source.
- **Eligibility**:
  - Let `t` = lowest set index of `inservice`, or N_SRC if none.
  - `irq_out[i] = pending[i] & mask[i] & (i < t)`.
  - `irq_req = |irq_out`.
- **CLAIM value**: id = lowest set index of `irq_out`, valid = `irq_req`.
- **Claim** (`re`=1, `we`=0, addr 3, valid=1):
  - Sets `inservice[id]`.
  - Clears `pending[id]` if edge mode.
  - With valid=0 it returns 0 and changes nothing.
- **Complete** (write to addr 3):
  - Clears `inservice[din[3:0]]`.
  - Ignored if `din[3:0]` ≥ N_SRC or that bit is already clear.
- **Priority of simultaneous events**:
  - A new edge beats a W1C or claim clear in the same cycle; pending stays 1.
  - Writing EDGE while a bit changes mode:
    - Edge→level: the pending bit follows `irq_in` from the next cycle.
    - Level→edge: pending is cleared at that edge.
- **Widths**: bits of `din` above N_SRC-1 are ignored; `dout` bits above N_SRC-1 read 0, except CLAIM bit31.

## Timing
- **Reset values**:
  - `samp`, `pending`, `mask`, `edge`, `inservice` all 0.
  - `irq_out`=0, `irq_req`=0.
  - `dout` reads 0 for every offset.
- **Request latency**:
  - `irq_in` rising before edge k gives `pending` at edge k.
  - `irq_out`/`irq_req` assert after edge k, with combinational delay only (1 cycle).
- **Write effects** (W1C, MASK, EOI) take effect at the same edge as the write; outputs update after that edge.
- **Claim timing**:
  - `dout` shows the pre-claim value during the `re` cycle.
  - `inservice`/`pending` update at the closing edge.
- **Mid-operation reset**: reset asserted mid-claim or mid-nest clears all in-service state immediately, without waiting for `clk`.

## Test plan
- **Reset**: assert reset with `irq_in`=6'h3F -> `irq_out`=0, `irq_req`=0, all registers read 0; after release, level sources with MASK=0 -> `irq_req` stays 0.
- **Edge latching and claim**:
  - Setup: EDGE=6'h01, MASK=6'h01; pulse `irq_in[0]` for 1 cycle.
  - Result: `irq_out`=6'h01 one cycle later; claim read returns 32'h80000000, PENDING reads 0, INSERVICE reads 6'h01.
  - EOI write 0 -> INSERVICE reads 0.
- **Nesting**:
  - Setup: MASK=6'h3F, level sources; hold `irq_in[2]`, claim -> id 2.
  - Raise `irq_in[4]` -> `irq_out`=0.
  - Raise `irq_in[1]` -> `irq_out`=6'h02; claim -> id 1; INSERVICE=6'h06.
  - EOI 1, then EOI 2 with only source 4 still active -> `irq_out`=6'h10.
- **Simultaneous events**: edge source 3 pending; in the same cycle write W1C 6'h08 and pulse a new `irq_in[3]` edge -> PENDING[3] stays 1.
- **Invalid operations**:
  - Claim with nothing eligible -> returns 0, INSERVICE unchanged.
  - EOI id 7 -> ignored.
  - Write to offset 6 -> no state change.
- **Mid-operation reset**: assert reset asynchronously between clock edges with INSERVICE=6'h05 -> INSERVICE reads 0 before the next `clk` edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl - memory-mapped interrupt controller.
//
// Latches edge- or level-type requests from N_SRC sources and masks them
// per source. Fixed priority applies: source 0 is highest. A claim/complete
// handshake records which sources are in service. While a source is in
// service, only strictly higher-priority requests reach the CPU.
//
// Register map (word offset on addr):
//   0 PENDING   R: pending vector, W: write-1-to-clear (edge-mode bits only)
//   1 MASK      R/W, 1 = source enabled
//   2 EDGE      R/W, 1 = rising-edge latched, 0 = level
//   3 CLAIM/EOI R: {valid[31], id[3:0]}, read with re=1 claims; W: complete id din[3:0]
//   4 RAW       R: registered samples of irq_in
//   5 INSERVICE R: in-service vector
//   other offsets read 0, writes ignored
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   we/re    register write / read strobes (re ignored while we=1)
//   addr     word offset
//   din      write data
//   dout     read data, combinational from addr and current state
//   irq_in   raw source requests, synchronous to clk
//   irq_out  eligible request vector to the CPU
//   irq_req  OR of irq_out

module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [2:0]       addr,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    input  logic [N_SRC-1:0] irq_in,
    output logic [N_SRC-1:0] irq_out,
    output logic             irq_req
);

    localparam int PAD = 32 - N_SRC;

    localparam logic [2:0] A_PENDING   = 3'd0;
    localparam logic [2:0] A_MASK      = 3'd1;
    localparam logic [2:0] A_EDGE      = 3'd2;
    localparam logic [2:0] A_CLAIM     = 3'd3;
    localparam logic [2:0] A_RAW       = 3'd4;
    localparam logic [2:0] A_INSERVICE = 3'd5;

    logic [N_SRC-1:0] samp_q,      samp_d;
    logic [N_SRC-1:0] pending_q,   pending_d;
    logic [N_SRC-1:0] mask_q,      mask_d;
    logic [N_SRC-1:0] edge_q,      edge_d;
    logic [N_SRC-1:0] inservice_q, inservice_d;

    logic [N_SRC-1:0] din_v;
    logic             din_unused;
    logic             wr_pending;
    logic             wr_mask;
    logic             wr_edge;
    logic             wr_eoi;
    logic             claim_rd;
    logic             claim_fire;

    logic [N_SRC-1:0] below_t;
    logic [N_SRC-1:0] eligible;
    logic [3:0]       claim_id;
    logic [N_SRC-1:0] claim_sel;
    logic [N_SRC-1:0] eoi_sel;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] w1c;

    // Only the low N_SRC data bits carry register content.
    assign din_v      = din[N_SRC-1:0];
    assign din_unused = ^din[31:N_SRC];

    // Bus decode
    always_comb begin
        wr_pending = we && (addr == A_PENDING);
        wr_mask    = we && (addr == A_MASK);
        wr_edge    = we && (addr == A_EDGE);
        wr_eoi     = we && (addr == A_CLAIM);
        claim_rd   = re && !we && (addr == A_CLAIM);
    end

    // Priority threshold: below_t[i] is set when no source at index <= i is
    // in service, i.e. i is strictly above the highest-priority in-service
    // source (or nothing is in service).
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        below_t = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (inservice_q[i]) begin
                blocked = 1'b1;
            end
            below_t[i] = ~blocked;
        end
    end

    assign eligible = pending_q & mask_q & below_t;

    // Lowest eligible index; scanning downward lets the lowest index win.
    always_comb begin
        claim_id = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                claim_id = 4'(i);
            end
        end
    end

    assign claim_fire = claim_rd && (|eligible);

    always_comb begin
        claim_sel = '0;
        eoi_sel   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            claim_sel[i] = claim_fire && (claim_id == 4'(i));
            // Out-of-range ids match no bit, so they are ignored naturally.
            eoi_sel[i]   = wr_eoi && (din[3:0] == 4'(i));
        end
    end

    assign rise = irq_in & ~samp_q;
    assign w1c  = wr_pending ? din_v : '0;

    // Pending update. The mode in force at this edge is edge_q. A bit that
    // switches level->edge here is cleared. A bit that switches edge->level
    // keeps its edge behaviour for this edge and tracks irq_in afterwards.
    // In edge mode a new rising edge beats a W1C or claim clear.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (wr_edge && din_v[i] && !edge_q[i]) begin
                pending_d[i] = 1'b0;
            end else if (edge_q[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~(w1c[i] | claim_sel[i]));
            end else begin
                pending_d[i] = irq_in[i];
            end
        end
    end

    always_comb begin
        samp_d      = irq_in;
        mask_d      = wr_mask ? din_v : mask_q;
        edge_d      = wr_edge ? din_v : edge_q;
        inservice_d = (inservice_q | claim_sel) & ~eoi_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_q      <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            edge_q      <= '0;
            inservice_q <= '0;
        end else begin
            samp_q      <= samp_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            edge_q      <= edge_d;
            inservice_q <= inservice_d;
        end
    end

    assign irq_out = eligible;
    assign irq_req = |eligible;

    // Read mux. With nothing eligible, claim_id is 0, so CLAIM reads 0.
    always_comb begin
        dout = 32'd0;
        case (addr)
            A_PENDING:   dout = {{PAD{1'b0}}, pending_q};
            A_MASK:      dout = {{PAD{1'b0}}, mask_q};
            A_EDGE:      dout = {{PAD{1'b0}}, edge_q};
            A_CLAIM:     dout = {irq_req, 27'd0, claim_id};
            A_RAW:       dout = {{PAD{1'b0}}, samp_q};
            A_INSERVICE: dout = {{PAD{1'b0}}, inservice_q};
            default:     dout = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Stimulus pushes expected values into a
// scoreboard queue and raises mon_en for one cycle. The monitor samples the
// DUT at the falling edge, pops the expectation, and compares.

module tb_irq_ctrl;

    localparam int N = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic          re;
    logic [2:0]    addr;
    logic [31:0]   din;
    logic [31:0]   dout;
    logic [N-1:0]  irq_in;
    logic [N-1:0]  irq_out;
    logic          irq_req;

    typedef struct {
        int          kind;   // 0 = dout, 1 = irq_out, 2 = irq_req
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    logic mon_en    = 1'b0;
    logic final_chk = 1'b0;
    logic final_done = 1'b0;
    int   total = 0;
    int   bad   = 0;

    irq_ctrl #(.N_SRC(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .re      (re),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .irq_in  (irq_in),
        .irq_out (irq_out),
        .irq_req (irq_req)
    );

    always #5 clk = ~clk;

    // Monitor / scoreboard checker
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t        e;
            logic [31:0] act;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: monitor active with no expectation queued");
            end else begin
                e = sb.pop_front();
                case (e.kind)
                    0:       act = dout;
                    1:       act = {26'd0, irq_out};
                    default: act = {31'd0, irq_req};
                endcase
                total++;
                if (act !== e.exp) begin
                    bad++;
                    $display("FAIL %s: actual=%h required=%h", e.name, act, e.exp);
                end
            end
        end
        if (final_chk && !final_done) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL sb_drain: actual=%0d leftover required=0", sb.size());
            end
            final_done <= 1'b1;
        end
    end

    task automatic push_exp(input int k, input string nm, input logic [31:0] e);
        exp_t x;
        x.kind = k;
        x.name = nm;
        x.exp  = e;
        sb.push_back(x);
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        we  = 1'b0;
        din = 32'd0;
    endtask

    task automatic exp_rd(input string nm, input logic [2:0] a, input logic r,
                          input logic [31:0] e);
        addr = a;
        re   = r;
        push_exp(0, nm, e);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        re     = 1'b0;
    endtask

    task automatic exp_irq(input string nm, input int k, input logic [31:0] e);
        push_exp(k, nm, e);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        we     = 1'b0;
        re     = 1'b0;
        addr   = 3'd0;
        din    = 32'd0;
        irq_in = 6'h3F;

        // Reset state with all sources asserted
        @(posedge clk);
        #1;
        exp_irq("rst_irq_out", 1, 32'h0);
        exp_irq("rst_irq_req", 2, 32'h0);
        for (int a = 0; a < 6; a++) begin
            exp_rd($sformatf("rst_reg%0d", a), 3'(a), 1'b0, 32'h0);
        end

        // Released: level sources latch but MASK=0 keeps irq_req low
        reset = 1'b0;
        idle(2);
        exp_irq("unmasked_req", 2, 32'h0);
        exp_rd("lvl_pending", 3'd0, 1'b0, 32'h3F);
        exp_rd("lvl_raw", 3'd4, 1'b0, 32'h3F);
        irq_in = 6'h00;
        idle(1);

        // Edge latching and claim
        wr(3'd2, 32'h01);
        wr(3'd1, 32'h01);
        irq_in = 6'h01;
        idle(1);
        irq_in = 6'h00;
        exp_irq("edge_irq_out", 1, 32'h01);
        exp_rd("edge_claim", 3'd3, 1'b1, 32'h8000_0000);
        exp_rd("edge_pend_after", 3'd0, 1'b0, 32'h0);
        exp_rd("edge_insvc", 3'd5, 1'b0, 32'h01);
        exp_irq("edge_out_after", 1, 32'h0);
        wr(3'd3, 32'd0);
        exp_rd("edge_eoi_insvc", 3'd5, 1'b0, 32'h0);

        // Nesting with level sources
        wr(3'd2, 32'h00);
        wr(3'd1, 32'h3F);
        irq_in = 6'h04;
        idle(1);
        exp_rd("nest_claim2", 3'd3, 1'b1, 32'h8000_0002);
        irq_in = 6'h14;
        idle(1);
        exp_irq("nest_low_blocked", 1, 32'h0);
        irq_in = 6'h16;
        idle(1);
        exp_irq("nest_high_out", 1, 32'h02);
        exp_rd("nest_claim1", 3'd3, 1'b1, 32'h8000_0001);
        exp_rd("nest_insvc", 3'd5, 1'b0, 32'h06);
        wr(3'd3, 32'd1);
        irq_in = 6'h10;
        wr(3'd3, 32'd2);
        exp_irq("nest_unwound_out", 1, 32'h10);
        exp_irq("nest_unwound_req", 2, 32'h1);

        // Edge beats a simultaneous W1C
        wr(3'd2, 32'h08);
        irq_in = 6'h18;
        idle(1);
        irq_in = 6'h10;
        idle(1);
        irq_in = 6'h18;
        wr(3'd0, 32'h08);
        irq_in = 6'h10;
        exp_rd("simul_pending", 3'd0, 1'b0, 32'h18);
        wr(3'd0, 32'h08);
        exp_rd("w1c_pending", 3'd0, 1'b0, 32'h10);

        // Invalid operations
        exp_rd("claim4", 3'd3, 1'b1, 32'h8000_0004);
        exp_rd("insvc4", 3'd5, 1'b0, 32'h10);
        wr(3'd3, 32'd7);
        exp_rd("eoi7_ignored", 3'd5, 1'b0, 32'h10);
        wr(3'd3, 32'd2);
        exp_rd("eoi_clear_bit", 3'd5, 1'b0, 32'h10);
        exp_rd("claim_none", 3'd3, 1'b1, 32'h0);
        exp_rd("claim_none_insvc", 3'd5, 1'b0, 32'h10);
        wr(3'd6, 32'hFFFF_FFFF);
        exp_rd("off6_mask", 3'd1, 1'b0, 32'h3F);
        exp_rd("off6_edge", 3'd2, 1'b0, 32'h08);
        exp_rd("off6_insvc", 3'd5, 1'b0, 32'h10);
        exp_rd("off6_read", 3'd6, 1'b0, 32'h0);
        wr(3'd3, 32'd4);
        exp_irq("eoi4_out", 1, 32'h10);

        // Mid-operation asynchronous reset
        irq_in = 6'h04;
        idle(1);
        exp_rd("mid_claim2", 3'd3, 1'b1, 32'h8000_0002);
        irq_in = 6'h05;
        idle(1);
        exp_rd("mid_claim0", 3'd3, 1'b1, 32'h8000_0000);
        exp_rd("mid_insvc", 3'd5, 1'b0, 32'h05);
        reset = 1'b1;
        exp_rd("async_rst_insvc", 3'd5, 1'b0, 32'h0);
        exp_irq("async_rst_req", 2, 32'h0);
        reset = 1'b0;
        irq_in = 6'h00;
        idle(1);

        final_chk = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
